// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - scan/scroll sequencer driving one nibble per digit slot to a shared 7-seg decoder
module seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int ID_LEN     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int SCROLL_DIV = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*ID_LEN-1:0]     id_in,
    input  logic                    scroll_en,
    input  logic                    clear,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [3:0]              digit_code,
    output logic                    frame_tick,
    output logic                    wrap
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = $clog2(SCROLL_DIV + 1);
    localparam int OW = $clog2(ID_LEN);
    localparam int SW = OW + 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_DIV - 1);
    localparam logic [SW-1:0] ID_LEN_S = SW'(ID_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [4*ID_LEN-1:0]    id_reg_q, id_reg_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [FW-1:0]          frm_q, frm_d;
    logic [OW-1:0]          off_q, off_d;
    logic [NUM_DIGITS-1:0]  digit_sel_q, digit_sel_d;
    logic [3:0]             digit_code_q, digit_code_d;
    logic                   frame_tick_q, frame_tick_d;
    logic                   wrap_q, wrap_d;

    logic                   tick;
    logic                   frame_end;
    logic [SW-1:0]          off_sum;
    logic [OW-1:0]          off_inc;
    logic [SW-1:0]          nib_sel;

    always_comb begin
        state_d      = state_q;
        id_reg_d     = id_reg_q;
        pre_d        = pre_q;
        idx_d        = idx_q;
        frm_d        = frm_q;
        off_d        = off_q;
        frame_tick_d = 1'b0;
        wrap_d       = 1'b0;

        tick      = (pre_q == PRE_LAST);
        frame_end = tick && (idx_q == IDX_LAST);

        // offset+1 mod ID_LEN by compare-and-subtract
        off_sum = {1'b0, off_q} + SW'(1);
        if (off_sum >= ID_LEN_S) begin
            off_sum = off_sum - ID_LEN_S;
        end
        off_inc = off_sum[OW-1:0];

        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            idx_d   = '0;
        end else if (load) begin
            id_reg_d = id_in;
            state_d  = scroll_en ? ST_SCROLL : ST_SHOW;
            pre_d    = '0;
            idx_d    = '0;
            frm_d    = '0;
            off_d    = '0;
        end else if (state_q != ST_IDLE) begin
            state_d      = scroll_en ? ST_SCROLL : ST_SHOW;
            pre_d        = tick ? '0 : pre_q + 1'b1;
            frame_tick_d = frame_end;
            if (tick) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            // scroll counting only while staying in SCROLL; re-entry restarts the frame count
            if (state_q == ST_SHOW && scroll_en) begin
                frm_d = '0;
            end else if (state_q == ST_SCROLL && scroll_en && frame_end) begin
                if (frm_q == FRM_LAST) begin
                    frm_d  = '0;
                    off_d  = off_inc;
                    wrap_d = (off_inc == '0);
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end
        end

        // outputs come from next-state values so select and code switch on the same edge
        nib_sel = {1'b0, off_d} + {{(SW-IW){1'b0}}, idx_d};
        if (nib_sel >= ID_LEN_S) begin
            nib_sel = nib_sel - ID_LEN_S;
        end

        digit_sel_d  = '0;
        digit_code_d = 4'h0;
        if (state_d != ST_IDLE) begin
            digit_sel_d[idx_d] = 1'b1;
            for (int k = 0; k < ID_LEN; k++) begin
                if (nib_sel == SW'(k)) begin
                    digit_code_d = id_reg_d[4*k +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            id_reg_q     <= '0;
            pre_q        <= '0;
            idx_q        <= '0;
            frm_q        <= '0;
            off_q        <= '0;
            digit_sel_q  <= '0;
            digit_code_q <= 4'h0;
            frame_tick_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_reg_q     <= id_reg_d;
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            frm_q        <= frm_d;
            off_q        <= off_d;
            digit_sel_q  <= digit_sel_d;
            digit_code_q <= digit_code_d;
            frame_tick_q <= frame_tick_d;
            wrap_q       <= wrap_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign digit_code = digit_code_q;
    assign frame_tick = frame_tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller against a cycle-count model
module tb_seg_scan_controller;

    localparam int NUM_DIGITS = 4;
    localparam int ID_LEN     = 8;
    localparam int SCAN_DIV   = 3;
    localparam int SCROLL_DIV = 2;
    localparam int FRAME      = SCAN_DIV * NUM_DIGITS;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load;
    logic [4*ID_LEN-1:0]   id_in;
    logic                  scroll_en;
    logic                  clear;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [3:0]            digit_code;
    logic                  frame_tick;
    logic                  wrap;

    seg_scan_controller #(
        .NUM_DIGITS (NUM_DIGITS),
        .ID_LEN     (ID_LEN),
        .SCAN_DIV   (SCAN_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .id_in      (id_in),
        .scroll_en  (scroll_en),
        .clear      (clear),
        .digit_sel  (digit_sel),
        .digit_code (digit_code),
        .frame_tick (frame_tick),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wrap_cnt = 0;

    // model: mode 0 idle, 1 static, 2 scrolling; m_t = active cycles since load
    int          m_mode, m_t, m_sf, m_off;
    logic [31:0] m_id;
    logic        m_ft, m_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [31:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_sf = 0; m_off = 0; m_id = '0; m_ft = 0; m_wr = 0;
    endtask

    task automatic model_edge();
        bit fe;
        m_ft = 0;
        m_wr = 0;
        if (rst) begin
            model_reset();
        end else if (clear) begin
            m_mode = 0;
            m_t    = 0;
        end else if (load) begin
            m_id   = id_in;
            m_mode = scroll_en ? 2 : 1;
            m_t    = 0;
            m_sf   = 0;
            m_off  = 0;
        end else if (m_mode != 0) begin
            fe = ((m_t % FRAME) == FRAME - 1);
            if (m_mode == 2 && scroll_en && fe) begin
                m_sf++;
                if (m_sf == SCROLL_DIV) begin
                    m_sf  = 0;
                    m_off = (m_off + 1) % ID_LEN;
                    m_wr  = (m_off == 0);
                end
            end else if (m_mode == 1 && scroll_en) begin
                m_sf = 0;
            end
            m_mode = scroll_en ? 2 : 1;
            m_ft   = fe;
            m_t++;
        end
    endtask

    task automatic check_model();
        int d;
        d = (m_t / SCAN_DIV) % NUM_DIGITS;
        chk("sel",  32'(digit_sel),  (m_mode != 0) ? (32'd1 << d) : 32'd0);
        chk("code", 32'(digit_code), (m_mode != 0) ? 32'(nib(m_id, (m_off + d) % ID_LEN)) : 32'd0);
        chk("ftick", 32'(frame_tick), 32'(m_ft));
        chk("wrap", 32'(wrap), 32'(m_wr));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        if (wrap) wrap_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; clear = 1'b0; scroll_en = 1'b0; id_in = '0;
        model_reset();
        run(2);
        #2 rst = 1'b0;
        run(3);
        chk("rst_sel", 32'(digit_sel), 32'd0);

        // static display
        id_in = 32'h1207_4561; load = 1'b1; scroll_en = 1'b0;
        step();
        load = 1'b0;
        chk("t2_sel0", 32'(digit_sel), 32'd1);
        chk("t2_code0", 32'(digit_code), 32'd1);
        run(3);
        chk("t2_sel1", 32'(digit_sel), 32'd2);
        chk("t2_code1", 32'(digit_code), 32'd6);
        run(9);
        chk("t2_ftick", 32'(frame_tick), 32'd1);
        chk("t2_sel_wrap", 32'(digit_sel), 32'd1);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("t1_sel", 32'(digit_sel), 32'd0);
        chk("t1_code", 32'(digit_code), 32'd0);
        model_reset();
        run(2);
        #2 rst = 1'b0;
        run(5);

        // scrolling
        id_in = 32'h1207_4561; load = 1'b1; scroll_en = 1'b1;
        step();
        load = 1'b0;
        run(24);
        chk("t3_code_d0", 32'(digit_code), 32'd6);
        run(9);
        chk("t3_sel_d3", 32'(digit_sel), 32'd8);
        chk("t3_code_d3", 32'(digit_code), 32'd7);
        wrap_cnt = 0;
        run(138);
        chk("t4_off7_d1", 32'(digit_code), 32'd1);
        run(21);
        chk("t4_wrap", 32'(wrap), 32'd1);
        chk("t4_wrap_ft", 32'(frame_tick), 32'd1);
        chk("t4_code", 32'(digit_code), 32'd1);
        chk("t4_wrap_cnt", 32'(wrap_cnt), 32'd1);

        // load and clear together
        id_in = 32'hDEAD_BEEF; load = 1'b1; clear = 1'b1;
        step();
        load = 1'b0; clear = 1'b0;
        chk("t5_sel", 32'(digit_sel), 32'd0);
        chk("t5_code", 32'(digit_code), 32'd0);
        run(2);
        id_in = 32'h89AB_CDE3; load = 1'b1; scroll_en = 1'b0;
        step();
        load = 1'b0;
        chk("t5_new_sel", 32'(digit_sel), 32'd1);
        chk("t5_new_code", 32'(digit_code), 32'd3);

        // freeze offset at 3
        id_in = 32'h1207_4561; load = 1'b1; scroll_en = 1'b1;
        step();
        load = 1'b0;
        run(72);
        chk("t6_off3", 32'(digit_code), 32'd4);
        scroll_en = 1'b0;
        wrap_cnt = 0;
        run(24);
        chk("t6_code_a", 32'(digit_code), 32'd4);
        run(48);
        chk("t6_code_b", 32'(digit_code), 32'd4);
        chk("t6_nowrap", 32'(wrap_cnt), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            load  = ($urandom_range(0, 59) == 0);
            clear = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 39) == 0) scroll_en = ~scroll_en;
            id_in = $urandom;
            step();
        end
        load = 1'b0; clear = 1'b0;
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
